multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multi-cycle RV32I core.
- Sequences every instruction through FETCH, DECODE, EXEC, MEM and WB.
- Latches the instruction register and drives the write/request strobes.
- Configures the immediate sign extender: enable, opcode select, signed/unsigned type, and the pre-packed raw immediate field.

Parameters:
- MEM_TIMEOUT, 255: maximum number of cycles spent in MEM waiting for mem_ready before a bus error is declared.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- instr_valid  in  1  fetched instruction is present on instr.
- instr  in  32  fetched instruction word.
- instr_ready  out  1  FSM is in FETCH and will accept an instruction.
- mem_ready  in  1  data memory has completed the current access.
- branch_taken  in  1  branch comparison result, valid in EXEC.
- ir  out  32  latched instruction register.
- se_en  out  1  sign extender enable.
- se_opcode  out  5  ir[6:2], fed to the sign extender op_code input.
- se_type  out  1  0 = signed, 1 = unsigned.
- imm_raw  out  32  packed immediate, fed to the sign extender input.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  0 = PC+4, 1 = branch/JAL target, 2 = JALR target.
- rf_we  out  1  register file write strobe.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write (store).
- retire  out  1  one-cycle pulse per completed instruction.
- ret_cnt  out  RET_W  count of retired instructions.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- illegal  out  1  sticky illegal-opcode flag.
- mem_err  out  1  sticky MEM timeout flag.

Behaviour:
- Reset (rst=0 at a clock edge, from any state, including mid-MEM):
  - state=FETCH, ir=32'h00000013 (NOP), wait counter=0, ret_cnt=0, illegal=0, mem_err=0.
  - All strobes are 0.
  - Outputs take these values in the first cycle after the edge.
- FETCH:
  - instr_ready=1.
  - On instr_valid: ir<=instr and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Legal opcodes (ir[6:2]) are 01101, 00101, 00100, 00000, 01000, 11001, 11011 and 11000. Any other opcode goes to TRAP.
- se_en: 1 in DECODE, EXEC, MEM and WB when the opcode is legal; 0 in FETCH and TRAP.
- se_opcode = ir[6:2] at all times.
- se_type = 1 only for:
  - opcode 00100 with funct3=011 (SLTIU);
  - opcode 00000 with funct3=100 or 101;
  - opcode 11000 with funct3=110 or 111.
  - In every other case se_type = 0.
- imm_raw packing (combinational from ir):
  - LUI/AUIPC: {ir[31:12], 12'b0}.
  - OP-IMM/LOAD: {20'b0, ir[31:20]}.
  - STORE: {{20{ir[31]}}, ir[31:25], ir[11:7]}.
  - JALR: {{20{ir[31]}}, ir[31:20]}.
  - JAL: {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0}.
  - BRANCH: {19'b0, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}.
  - Otherwise: 0.
- EXEC (1 cycle):
  - LOAD/STORE go to MEM.
  - BRANCH: pc_we=1, pc_src = branch_taken ? 1 : 0, retire=1, go to FETCH.
  - All others go to WB.
- MEM:
  - mem_req=1 and mem_we=(opcode==01000), held until mem_ready.
  - The wait counter increments on each cycle without mem_ready.
  - mem_ready=1: LOAD goes to WB; STORE asserts pc_we=1, pc_src=0, retire=1 and goes to FETCH. The counter clears.
  - If the counter reaches MEM_TIMEOUT without mem_ready: set mem_err and go to TRAP.
  - If mem_ready arrives on the same cycle the counter reaches MEM_TIMEOUT, mem_ready wins.
- WB (1 cycle):
  - rf_we=1, pc_we=1, retire=1, then go to FETCH.
  - pc_src: JAL=1, JALR=2, all others 0.
- TRAP:
  - Every strobe is 0 and instr_ready=0.
  - Only reset exits TRAP.
  - illegal is set on entry from DECODE.
- ret_cnt increments on every retire and wraps at 2^RET_W to 0.
- Latency per instruction, counting from the instr_valid accept edge (FETCH cycle excluded):
  - ALU/LUI/JAL: 3 cycles.
  - Branch: 2 cycles.
  - Store: 2 + n cycles.
  - Load: 3 + n cycles.
  - n = number of MEM cycles, including the mem_ready cycle (n ≥ 1).
- At most one of pc_we/rf_we retire events occurs per instruction; retire coincides with the final pc_we.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), instr_valid=1 in FETCH: DECODE shows se_en=1, se_opcode=00100, se_type=0, imm_raw=0x00000FFF. rf_we, pc_we and retire all pulse in WB, 3 cycles after accept. ret_cnt=1.
- SLTIU (0xFFF03093): se_type=1, imm_raw=0x00000FFF. BLTU with funct3=110, branch_taken=1: EXEC gives pc_we=1, pc_src=1, se_type=1, and FETCH follows.
- LW (0x00402103), mem_ready asserted on the 3rd MEM cycle: mem_req=1 for exactly 3 cycles, mem_we=0, then WB with rf_we=1. Total 6 cycles.
- Illegal opcode 0x0000007F: DECODE→TRAP, illegal=1, instr_ready stays 0 for 20 cycles. rst=0 for one edge then returns to FETCH with illegal=0.
- SW with mem_ready never asserted and MEM_TIMEOUT=4: after 4 MEM cycles, mem_err=1 and state=7.
- rst=0 during the 2nd MEM cycle of a load: the next cycle has state=FETCH, mem_req=0, ir=0x00000013 and ret_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm_if
// Purpose  : Fetch/memory handshake and control-strobe bundle for the
//            multi-cycle RV32I control FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_fsm_if #(
    parameter int RET_W = 32
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             mem_ready;
    logic             branch_taken;
    logic [31:0]      ir;
    logic             se_en;
    logic [4:0]       se_opcode;
    logic             se_type;
    logic [31:0]      imm_raw;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             rf_we;
    logic             mem_req;
    logic             mem_we;
    logic             retire;
    logic [RET_W-1:0] ret_cnt;
    logic [2:0]       state;
    logic             illegal;
    logic             mem_err;

    // master: the control FSM; slave: the surrounding datapath/memory
    modport master (
        input  instr_valid, instr, mem_ready, branch_taken,
        output instr_ready, ir, se_en, se_opcode, se_type, imm_raw,
               pc_we, pc_src, rf_we, mem_req, mem_we, retire, ret_cnt,
               state, illegal, mem_err
    );

    modport slave (
        output instr_valid, instr, mem_ready, branch_taken,
        input  instr_ready, ir, se_en, se_opcode, se_type, imm_raw,
               pc_we, pc_src, rf_we, mem_req, mem_we, retire, ret_cnt,
               state, illegal, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Main FETCH/DECODE/EXEC/MEM/WB sequencer of the multi-cycle RV32I
//            core; owns the IR, control strobes and sign-extender setup.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int RET_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    multicycle_ctrl_fsm_if.master bus
);
    localparam int          c_CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [31:0] c_NOP       = 32'h0000_0013;
    localparam logic [4:0]  c_OP_LUI    = 5'b01101;
    localparam logic [4:0]  c_OP_AUIPC  = 5'b00101;
    localparam logic [4:0]  c_OP_IMM    = 5'b00100;
    localparam logic [4:0]  c_OP_LOAD   = 5'b00000;
    localparam logic [4:0]  c_OP_STORE  = 5'b01000;
    localparam logic [4:0]  c_OP_JALR   = 5'b11001;
    localparam logic [4:0]  c_OP_JAL    = 5'b11011;
    localparam logic [4:0]  c_OP_BRANCH = 5'b11000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_ir;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [RET_W-1:0]   r_ret_cnt;
    logic               r_illegal;
    logic               r_mem_err;

    logic [4:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_legal;
    logic        w_se_type;
    logic [31:0] w_imm_raw;
    logic        w_instr_ready;
    logic        w_pc_we;
    logic [1:0]  w_pc_src;
    logic        w_rf_we;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_retire;
    logic        w_set_illegal;
    logic        w_set_mem_err;

    assign w_opcode = r_ir[6:2];
    assign w_funct3 = r_ir[14:12];

    always_comb begin
        w_legal   = 1'b0;
        w_se_type = 1'b0;
        w_imm_raw = 32'h0;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC: begin
                w_legal   = 1'b1;
                w_imm_raw = {r_ir[31:12], 12'b0};
            end
            c_OP_IMM: begin
                w_legal   = 1'b1;
                w_se_type = (w_funct3 == 3'b011);
                w_imm_raw = {20'b0, r_ir[31:20]};
            end
            c_OP_LOAD: begin
                w_legal   = 1'b1;
                w_se_type = (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
                w_imm_raw = {20'b0, r_ir[31:20]};
            end
            c_OP_STORE: begin
                w_legal   = 1'b1;
                w_imm_raw = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            end
            c_OP_JALR: begin
                w_legal   = 1'b1;
                w_imm_raw = {{20{r_ir[31]}}, r_ir[31:20]};
            end
            c_OP_JAL: begin
                w_legal   = 1'b1;
                w_imm_raw = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            end
            c_OP_BRANCH: begin
                w_legal   = 1'b1;
                w_se_type = (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
                w_imm_raw = {19'b0, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next_state  = r_state;
        w_instr_ready = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_src      = 2'd0;
        w_rf_we       = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_mem_err = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next_state  = w_legal ? S_EXEC : S_TRAP;
                w_set_illegal = !w_legal;
            end
            S_EXEC: begin
                if ((w_opcode == c_OP_LOAD) || (w_opcode == c_OP_STORE)) begin
                    w_next_state = S_MEM;
                end else if (w_opcode == c_OP_BRANCH) begin
                    w_pc_we      = 1'b1;
                    w_pc_src     = bus.branch_taken ? 2'd1 : 2'd0;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_opcode == c_OP_STORE);
                // A ready on the final allowed cycle still completes the access
                if (bus.mem_ready) begin
                    if (w_opcode == c_OP_STORE) begin
                        w_pc_we      = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (r_wait_cnt == c_CNT_W'(MEM_TIMEOUT - 1)) begin
                    w_set_mem_err = 1'b1;
                    w_next_state  = S_TRAP;
                end
            end
            S_WB: begin
                w_rf_we      = 1'b1;
                w_pc_we      = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
                if (w_opcode == c_OP_JAL) begin
                    w_pc_src = 2'd1;
                end else if (w_opcode == c_OP_JALR) begin
                    w_pc_src = 2'd2;
                end
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_ir       <= c_NOP;
            r_wait_cnt <= '0;
            r_ret_cnt  <= '0;
            r_illegal  <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_FETCH) && bus.instr_valid) begin
                r_ir <= bus.instr;
            end
            if ((r_state == S_MEM) && !bus.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_retire) begin
                r_ret_cnt <= r_ret_cnt + RET_W'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_mem_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign bus.instr_ready = w_instr_ready;
    assign bus.ir          = r_ir;
    assign bus.se_en       = w_legal && (r_state != S_FETCH) && (r_state != S_TRAP);
    assign bus.se_opcode   = w_opcode;
    assign bus.se_type     = w_se_type;
    assign bus.imm_raw     = w_imm_raw;
    assign bus.pc_we       = w_pc_we;
    assign bus.pc_src      = w_pc_src;
    assign bus.rf_we       = w_rf_we;
    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = w_mem_we;
    assign bus.retire      = w_retire;
    assign bus.ret_cnt     = r_ret_cnt;
    assign bus.state       = r_state;
    assign bus.illegal     = r_illegal;
    assign bus.mem_err     = r_mem_err;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Purpose  : Directed plus randomized instruction stream against an
//            instruction-level model of latency, strobes and immediates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;
    localparam int MEM_TIMEOUT = 4;
    localparam int RET_W       = 4;
    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_ILL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_ret  = 0;
    logic [4:0] legal_ops [8] = '{5'b01101, 5'b00101, 5'b00100, 5'b00000,
                                  5'b01000, 5'b11001, 5'b11011, 5'b11000};

    multicycle_ctrl_fsm_if #(.RET_W(RET_W)) bus ();

    multicycle_ctrl_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .RET_W       (RET_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic int ref_kind(input logic [4:0] op);
        case (op)
            5'b11000: return K_BR;
            5'b00000: return K_LD;
            5'b01000: return K_ST;
            5'b01101, 5'b00101, 5'b00100, 5'b11001, 5'b11011: return K_ALU;
            default:  return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        case (i[6:2])
            5'b01101, 5'b00101: return i & 32'hFFFF_F000;
            5'b00100, 5'b00000: return i >> 20;
            5'b01000: begin
                v = int'({i[31:25], i[11:7]});
                if (v >= 2048) v -= 4096;
                return 32'(v);
            end
            5'b11001: begin
                v = int'(i[31:20]);
                if (v >= 2048) v -= 4096;
                return 32'(v);
            end
            5'b11011: begin
                v = int'({i[31], i[19:12], i[20], i[30:21], 1'b0});
                if (v >= (1 << 20)) v -= (1 << 21);
                return 32'(v);
            end
            5'b11000: return 32'({i[31], i[7], i[30:25], i[11:8], 1'b0});
            default:  return 32'h0;
        endcase
    endfunction

    // Unsigned flavours: SLTIU, LBU/LHU, BLTU/BGEU
    function automatic bit ref_unsigned(input logic [31:0] i);
        int f3;
        f3 = int'(i[14:12]);
        return (i[6:2] == 5'b00100 && f3 == 3) ||
               (i[6:2] == 5'b00000 && (f3 == 4 || f3 == 5)) ||
               (i[6:2] == 5'b11000 && f3 >= 6);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_ret = 0;
        @(negedge clk);
        check_val("rst_state",   32'(bus.state),       32'd0);
        check_val("rst_ir",      bus.ir,               32'h0000_0013);
        check_val("rst_ret_cnt", 32'(bus.ret_cnt),     32'd0);
        check_val("rst_illegal", 32'(bus.illegal),     32'd0);
        check_val("rst_mem_err", 32'(bus.mem_err),     32'd0);
        check_val("rst_strobes", 32'({bus.pc_we, bus.rf_we, bus.mem_req, bus.retire}), 32'd0);
        check_val("rst_ready",   32'(bus.instr_ready), 32'd1);
    endtask

    task automatic run_instr(input logic [31:0] word, input int n, input bit taken);
        int k, lat, cyc, bad;
        int n_ret, n_pcwe, n_rfwe, n_memreq, n_memwe, retire_cyc, rf_cyc;
        logic [1:0] src, exp_src;
        bit done, timeout;
        k = ref_kind(word[6:2]);
        timeout = (k == K_LD || k == K_ST) && (n > MEM_TIMEOUT);
        n_ret = 0; n_pcwe = 0; n_rfwe = 0; n_memreq = 0; n_memwe = 0;
        retire_cyc = -1; rf_cyc = -1; src = 2'd0;
        case (k)
            K_BR:    lat = 2;
            K_ST:    lat = 2 + n;
            K_LD:    lat = 3 + n;
            default: lat = 3;
        endcase
        exp_src = (word[6:2] == 5'b11011 || (k == K_BR && taken)) ? 2'd1 :
                  (word[6:2] == 5'b11001) ? 2'd2 : 2'd0;

        @(posedge clk); #1;
        bus.instr = word; bus.instr_valid = 1'b1;
        bus.branch_taken = taken; bus.mem_ready = 1'b0;
        @(negedge clk);
        check_val("fetch_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.instr = $urandom;

        cyc = 1; done = 1'b0;
        while (!done) begin
            bus.mem_ready = (cyc == 2 + n);
            @(negedge clk);
            if (cyc == 1) begin
                check_val("dec_state",   32'(bus.state),     32'd1);
                check_val("dec_ir",      bus.ir,             word);
                check_val("dec_se_en",   32'(bus.se_en),     32'(k != K_ILL));
                check_val("dec_se_op",   32'(bus.se_opcode), 32'(word[6:2]));
                check_val("dec_se_type", 32'(bus.se_type),   32'(ref_unsigned(word)));
                check_val("dec_imm_raw", bus.imm_raw,        ref_imm(word));
            end
            if (bus.retire) begin n_ret++; retire_cyc = cyc; src = bus.pc_src; end
            if (bus.pc_we)   n_pcwe++;
            if (bus.rf_we)   begin n_rfwe++; rf_cyc = cyc; end
            if (bus.mem_req) n_memreq++;
            if (bus.mem_we)  n_memwe++;
            @(posedge clk); #1;
            if (bus.state == 3'd0 || bus.state == 3'd7) done = 1'b1;
            else if (cyc >= 30) begin
                check_val("watchdog_state", 32'(bus.state), 32'd0);
                done = 1'b1;
            end else cyc++;
        end
        bus.mem_ready = 1'b0;

        if (k == K_ILL) begin
            check_val("ill_cycles",  32'(cyc),         32'd1);
            check_val("ill_state",   32'(bus.state),   32'd7);
            check_val("ill_flag",    32'(bus.illegal), 32'd1);
            bad = 0;
            bus.instr_valid = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (bus.instr_ready || bus.pc_we || bus.retire || bus.se_en) bad++;
            end
            check_val("trap_quiet",  32'(bad),         32'd0);
            check_val("trap_hold",   32'(bus.state),   32'd7);
            do_reset();
        end else if (timeout) begin
            check_val("to_cycles",   32'(cyc),         32'(2 + MEM_TIMEOUT));
            check_val("to_state",    32'(bus.state),   32'd7);
            check_val("to_mem_err",  32'(bus.mem_err), 32'd1);
            check_val("to_memreq",   32'(n_memreq),    32'(MEM_TIMEOUT));
            check_val("to_retire",   32'(n_ret),       32'd0);
            do_reset();
        end else begin
            exp_ret++;
            check_val("latency",     32'(cyc),         32'(lat));
            check_val("retire_cyc",  32'(retire_cyc),  32'(lat));
            check_val("retire_cnt",  32'(n_ret),       32'd1);
            check_val("pc_we_cnt",   32'(n_pcwe),      32'd1);
            check_val("rf_we_cnt",   32'(n_rfwe),      32'((k == K_ALU || k == K_LD) ? 1 : 0));
            if (n_rfwe != 0) check_val("rf_we_cyc", 32'(rf_cyc), 32'(lat));
            check_val("mem_req_cnt", 32'(n_memreq),    32'((k == K_LD || k == K_ST) ? n : 0));
            check_val("mem_we_cnt",  32'(n_memwe),     32'((k == K_ST) ? n : 0));
            check_val("pc_src",      32'(src),         32'(exp_src));
            check_val("ret_cnt",     32'(bus.ret_cnt), 32'(exp_ret % (1 << RET_W)));
            check_val("flags",       32'({bus.illegal, bus.mem_err}), 32'd0);
        end
    endtask

    task automatic reset_mid_mem();
        @(posedge clk); #1;
        bus.instr = 32'h0040_2103; bus.instr_valid = 1'b1; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_val("mid_mem_state", 32'(bus.state), 32'd3);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("mid_rst_state",   32'(bus.state),   32'd0);
        check_val("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("mid_rst_ir",      bus.ir,           32'h0000_0013);
        check_val("mid_rst_ret_cnt", 32'(bus.ret_cnt), 32'd0);
        rst = 1'b1;
        exp_ret = 0;
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0]  op;
        int          pick;
        bus.instr_valid = 1'b0; bus.instr = 32'h0;
        bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
        do_reset();

        run_instr(32'hFFF0_0093, 1, 1'b0);            // ADDI x1,x0,-1
        run_instr(32'hFFF0_3093, 1, 1'b0);            // SLTIU
        run_instr(32'h0020_E463, 1, 1'b1);            // BLTU, taken
        run_instr(32'h0040_2103, 3, 1'b0);            // LW, ready on 3rd MEM cycle
        run_instr(32'h0000_007F, 1, 1'b0);            // illegal opcode
        run_instr(32'h0011_2223, MEM_TIMEOUT + 1, 1'b0); // SW, never ready
        run_instr(32'h0011_2223, MEM_TIMEOUT, 1'b0);  // SW, ready on last allowed cycle
        reset_mid_mem();
        for (int i = 0; i < 18; i++) run_instr(32'h0010_8093, 1, 1'b0); // ret_cnt wraps

        for (int i = 0; i < 60; i++) begin
            w    = $urandom;
            pick = $urandom_range(0, 19);
            if (pick == 0) begin
                do op = 5'($urandom); while (ref_kind(op) != K_ILL);
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            w[6:0] = {op, 2'b11};
            run_instr(w, (pick == 1) ? MEM_TIMEOUT + 1 : $urandom_range(1, MEM_TIMEOUT),
                      1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
